// File: rtl/ifid_stage.sv
// IF/ID stage: latches fetched instr/pc/npc for decode; stall hold, flush.
// Define IFID_SKID_EN for a 2-entry skid buffer that decouples fetch_ready from stall.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;
endpackage

module ifid_stage
  import cpu_types_pkg::*;
#(
  parameter word_t NOP_INSTR = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  word_t      imemload,
  input  word_t      pc_in,
  input  word_t      npc_in,
  input  logic       stall,
  input  logic       flush,
  output word_t      instr_out,
  output word_t      pc_out,
  output word_t      npc_out,
  output logic       valid_out,
  output logic       fetch_ready,
  output logic [1:0] count
);

`ifdef IFID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam ifid_t EMPTY = '{
    instr: NOP_INSTR,
    pc:    '0,
    npc:   '0
  };

  ifid_t      r_q [DEPTH];
  logic [1:0] r_cnt;
  logic       r_valid;

  ifid_t      w_q [DEPTH];
  logic [1:0] w_pos;
  logic [1:0] w_cnt;
  logic       w_rdy;
  logic       w_enq;
  logic       w_deq;
  ifid_t      w_new;

`ifdef IFID_SKID_EN
  assign w_rdy = (r_cnt != 2'd2);
`else
  assign w_rdy = (r_cnt == 2'd0) || !stall;
`endif

  assign w_enq = ihit && w_rdy && !flush;
  assign w_deq = r_valid && !stall && !flush;
  assign w_new = '{instr: imemload, pc: pc_in, npc: npc_in};

  // Vacated slots are refilled with EMPTY so the head is always the output value.
  always_comb begin
    w_q   = r_q;
    w_pos = r_cnt;
    if (w_deq) begin
      for (int i = 0; i < DEPTH - 1; i++)
        w_q[i] = r_q[i+1];
      w_q[DEPTH-1] = EMPTY;
      w_pos = r_cnt - 2'd1;
    end
    if (w_enq) begin
      for (int i = 0; i < DEPTH; i++)
        if (w_pos == 2'(i))
          w_q[i] = w_new;
    end
    w_cnt = w_pos + 2'(w_enq);
    if (flush) begin
      w_cnt = 2'd0;
      for (int i = 0; i < DEPTH; i++)
        w_q[i] = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= EMPTY;
    end else begin
      r_cnt   <= w_cnt;
      r_valid <= (w_cnt != 2'd0);
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= w_q[i];
    end
  end

  assign instr_out   = r_q[0].instr;
  assign pc_out      = r_q[0].pc;
  assign npc_out     = r_q[0].npc;
  assign valid_out   = r_valid;
  assign count       = r_cnt;
  assign fetch_ready = w_rdy;

endmodule
